cpeta_adder: RTL and testbench
==============================

Name:
cpeta_adder

Overview:
- Registered N-bit approximate adder of the Carry-Prediction Error-Tolerant Adder (CPETA) type. Used in the approximate-arithmetic datapath and characterised for error rate, MED, MRED and NMED.
- The operand is split into two parts:
  - Lower inexact part: K bits, computed with the ETA-I rule.
  - Upper exact part: N-K bits, a true adder whose carry-in is predicted from the top bits of the lower part.
- The result is truncated to N bits and registered once.

Parameters:
- n, 16, total operand and sum width; n >= 2.
- k, 11, width of the lower inexact part; 1 <= k <= n-1. Upper exact part width is n-k.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B are sampled this cycle when high.
- A  input  n  unsigned operand A.
- B  input  n  unsigned operand B.
- sum  output  n  registered approximate sum, mod 2^n.
- out_valid  output  1  high the cycle after an accepted in_valid.

Behaviour:
- Per-bit signals: G[i] = A[i]&B[i], P[i] = A[i]^B[i].
- Lower part, bits k-1..0 (ETA-I rule):
  - Scan from bit k-1 down to bit 0. Let j be the highest index in [k-1:0] with G[j]=1.
  - Bits above j: sum bit = P[i].
  - Bit j and every bit below it: sum bit = 1.
  - If no such j exists, lower sum = P[k-1:0].
  - No carry propagates inside the lower part.
- Carry prediction into the upper part:
  - k >= 2: c_k = G[k-1] | (P[k-1] & G[k-2]).
  - k = 1: c_k = G[0].
- Upper part, bits n-1..k: exact sum A[n-1:k] + B[n-1:k] + c_k.
  - Keep the low n-k bits; drop the carry-out. There is no carry-out port.
- Datapath is purely combinational from A/B to the output register.
  - Latency 1 cycle: inputs sampled at edge t appear on sum at edge t (visible after t).
  - Throughput 1 result per cycle.
- Handshake:
  - in_valid=1 at an edge: sum <= approximate result; out_valid <= 1.
  - in_valid=0 at an edge: sum holds its previous value; out_valid <= 0.
- Reset (rst=1 at an edge): sum <= 0, out_valid <= 0. rst has priority over in_valid; an in-flight result is discarded.
- Exactness property: when no G[i]=1 for i in [k-1:0], the result equals the exact (A+B) mod 2^n.
- Overflow: the upper part wraps modulo 2^(n-k), so sum is (approx) mod 2^n.
- Operands are treated as unsigned; no X-propagation special handling is required.

Test Plan:
(all cases n=16, k=11, in_valid=1 unless stated)
- Reset: rst=1 for 2 cycles -> sum=0x0000 and out_valid=0. Release rst with in_valid=0 -> outputs stay 0.
- No lower generate: A=0x0003, B=0x0004 -> next cycle sum=0x0007 (exact), out_valid=1.
- Lower-bit generate, no predicted carry: A=0x0001, B=0x0001 -> sum=0x0001 (exact value 0x0002; error 1).
- Generate at bit 10: A=0x0400, B=0x0400 -> lower part 0x7FF, c_k=1, sum=0x0FFF (exact 0x0800).
- Propagate-plus-generate prediction: A=0x0600, B=0x0200 -> c_k=1 via P[10]&G[9], sum=0x0FFF.
- Upper overflow and hold: A=0xF800, B=0x0800 -> sum=0x0000. Then drop in_valid for 3 cycles -> sum holds 0x0000 and out_valid=0.
- Random regression: 10^7 random pairs against a golden model of this spec -> exact match. Also report ER/MED/MRED/NMED against the exact sum.

Source files
------------

// File: rtl/cpeta_adder.sv
// -----------------------------------------------------------------------------
// cpeta_adder -- registered n-bit Carry-Prediction Error-Tolerant Adder.
//
// The operand is split at bit k:
//   * bits k-1..0 (inexact): ETA-I rule. Scanning downward from bit k-1, each
//     bit is A^B until the first bit where A&B=1. That bit and every bit below
//     it are forced to 1. No carry moves inside this part.
//   * bits n-1..k (exact): a true adder whose carry-in is predicted from the
//     two most significant bits of the lower part. The carry-out is dropped,
//     so the result wraps modulo 2^n.
// The combinational result is registered once: latency 1, throughput 1.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (priority over in_valid)
//   in_valid   in   A/B are sampled at this edge when high
//   A, B       in   n-bit unsigned operands
//   sum        out  registered approximate sum, mod 2^n (holds when idle)
//   out_valid  out  high the cycle after an accepted in_valid
// -----------------------------------------------------------------------------
module cpeta_adder #(
  parameter int n = 16,
  parameter int k = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] sum,
  output logic         out_valid
);

  // Per-bit generate/propagate. Only the lower part needs them, because the
  // upper part is a plain adder.
  logic [k-1:0]   g;
  logic [k-1:0]   p;
  logic [k-1:0]   lower;
  logic           c_k;
  logic [n-k-1:0] upper;
  logic [n-1:0]   sum_d;
  logic [n-1:0]   sum_q;
  logic           valid_q;
  logic           seen;

  assign g = A[k-1:0] & B[k-1:0];
  assign p = A[k-1:0] ^ B[k-1:0];

  // ETA-I lower part. 'seen' goes high at the highest generate bit and stays
  // high for every bit below it, which saturates those bits to 1.
  // NOTE: defaults are assigned before the loop so that every path writes
  // every variable; without them this block would infer latches.
  always_comb begin
    seen  = 1'b0;
    lower = '0;
    for (int i = k - 1; i >= 0; i--) begin
      seen     = seen | g[i];
      lower[i] = seen | p[i];
    end
  end

  // Carry prediction into the exact part. It uses only the top two lower bits.
  generate
    if (k >= 2) begin : g_pred2
      assign c_k = g[k-1] | (p[k-1] & g[k-2]);
    end else begin : g_pred1
      assign c_k = g[0];
    end
  endgenerate

  // Exact upper part. The result is kept to n-k bits, so the carry-out drops
  // and the sum wraps.
  assign upper = A[n-1:k] + B[n-1:k] + (n-k)'(c_k);
  assign sum_d = {upper, lower};

  // NOTE: state registers use non-blocking assignments. All flops then update
  // together at the edge, and downstream logic sees no ordering race.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cpeta_adder.sv
// -----------------------------------------------------------------------------
// tb_cpeta_adder -- self-checking bench for cpeta_adder (n=16, k=11).
// Runs directed vectors with hand-computed results, followed by a short random
// sweep. The sweep checks against an independent model and reports
// ER/MED/MRED/NMED against the exact sum.
// -----------------------------------------------------------------------------
module tb_cpeta_adder;

  localparam int N = 16;
  localparam int K = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] sum;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  cpeta_adder #(.n(N), .k(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .sum      (sum),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the inputs on the falling edge, let one rising edge pass, and then
  // sample just after that edge.
  task automatic step(input logic r, input logic v, input logic [N-1:0] av,
                      input logic [N-1:0] bv);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  // Reference model. It finds the highest lower-part generate bit by scanning
  // upward, then builds the sum from masks.
  function automatic logic [N-1:0] model(input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    logic [K-1:0]   gen;
    logic [K-1:0]   low;
    logic [K-1:0]   below;
    logic [N-K-1:0] hi;
    logic           c;
    int             j;
    gen = x[K-1:0] & y[K-1:0];
    j   = -1;
    for (int i = 0; i < K; i++) if (gen[i]) j = i;
    below = '0;
    for (int i = 0; i < K; i++) if (i <= j) below[i] = 1'b1;
    low = (x[K-1:0] ^ y[K-1:0]) | below;
    c   = gen[K-1] | ((x[K-1] ^ y[K-1]) & gen[K-2]);
    hi  = x[N-1:K] + y[N-1:K] + {{(N-K-1){1'b0}}, c};
    return {hi, low};
  endfunction

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] exp_sum;
    logic [N:0]   exact;
    int           err_cnt;
    real          abs_err;
    real          sum_ed;
    real          sum_red;
    int           n_rand;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

    // Hold reset for two cycles.
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("reset_sum",   sum,       16'h0000);
    check("reset_valid", out_valid, 1'b0);

    // Release reset with no valid input: the outputs stay at zero.
    step(1'b0, 1'b0, 16'h1111, 16'h2222);
    check("idle_sum",   sum,       16'h0000);
    check("idle_valid", out_valid, 1'b0);

    // No lower generate, so the result is exact.
    step(1'b0, 1'b1, 16'h0003, 16'h0004);
    check("nogen_sum",   sum,       16'h0007);
    check("nogen_valid", out_valid, 1'b1);

    // Generate at bit 0 with no predicted carry.
    step(1'b0, 1'b1, 16'h0001, 16'h0001);
    check("gen0_sum", sum, 16'h0001);

    // Generate at bit 10: lower part 0x7FF and c_k=1.
    step(1'b0, 1'b1, 16'h0400, 16'h0400);
    check("gen10_sum", sum, 16'h0FFF);

    // c_k comes from P[10]&G[9].
    step(1'b0, 1'b1, 16'h0600, 16'h0200);
    check("pg_pred_sum", sum, 16'h0FFF);

    // Generate at bit 0 with a propagate chain above it and no prediction.
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001);
    check("chain_sum", sum, 16'hFFFF);

    // No lower generate, with an upper-part sum.
    step(1'b0, 1'b1, 16'h1234, 16'h1000);
    check("exact_upper_sum", sum, 16'h2234);

    // The upper part overflows and wraps.
    step(1'b0, 1'b1, 16'hF800, 16'h0800);
    check("ovf_sum",   sum,       16'h0000);
    check("ovf_valid", out_valid, 1'b1);

    // Drop in_valid for three cycles: sum holds and out_valid stays low.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'hAAAA, 16'h5555);
      check("hold_sum",   sum,       16'h0000);
      check("hold_valid", out_valid, 1'b0);
    end

    // Hold a nonzero value across an idle cycle.
    step(1'b0, 1'b1, 16'h0003, 16'h0004);
    step(1'b0, 0, 16'h0400, 16'h0400);
    check("hold_nz_sum",   sum,       16'h0007);
    check("hold_nz_valid", out_valid, 1'b0);

    // Reset has priority over in_valid.
    step(1'b1, 1'b1, 16'h0400, 16'h0400);
    check("rst_prio_sum",   sum,       16'h0000);
    check("rst_prio_valid", out_valid, 1'b0);

    // Short random sweep against the reference model, with error statistics.
    err_cnt = 0; sum_ed = 0.0; sum_red = 0.0; n_rand = 2000;
    for (int i = 0; i < n_rand; i++) begin
      ra      = N'($urandom);
      rb      = N'($urandom);
      exp_sum = model(ra, rb);
      step(1'b0, 1'b1, ra, rb);
      check("rand_sum", sum, exp_sum);
      exact   = {1'b0, ra} + {1'b0, rb};
      abs_err = (exact >= {1'b0, sum}) ? real'(exact - {1'b0, sum})
                                       : real'({1'b0, sum} - exact);
      if (abs_err != 0.0) err_cnt++;
      sum_ed += abs_err;
      if (exact != 0) sum_red += abs_err / real'(exact);
    end
    $display("Stats: ER=%f MED=%f MRED=%f NMED=%f",
             real'(err_cnt) / real'(n_rand), sum_ed / real'(n_rand),
             sum_red / real'(n_rand),
             (sum_ed / real'(n_rand)) / real'((1 << N) - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
